// File: rtl/noc_bridge_pkg.sv
// noc_bridge_pkg: shared credit/VC types and the default credit depth for the NoC bridge
package noc_bridge_pkg;
  localparam int NumCredNocBridge = 8;
  localparam int CredWNocBridge = $clog2(NumCredNocBridge + 1);
  localparam int NumVcNocBridge = 2;
  localparam int VcIdxWNocBridge = (NumVcNocBridge > 1) ? $clog2(NumVcNocBridge) : 1;
  typedef logic [CredWNocBridge-1:0] bridge_credit_t;
  typedef logic [VcIdxWNocBridge-1:0] vc_idx_t;
  typedef struct packed {
    vc_idx_t        data_vc;
    logic           data_valid;
    vc_idx_t        cred_vc;
    bridge_credit_t credits;
  } pkt_meta_t;
endpackage

// File: rtl/noc_bridge_vc_credit_counter.sv
// noc_bridge_vc_credit_counter: saturating remote/pending credit counters of one VC with sticky overflow
module noc_bridge_vc_credit_counter #(
  parameter int NumCred = 8,
  parameter int CredW = $clog2(NumCred + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             remote_dec,
  input  logic [CredW-1:0] remote_add,
  input  logic [CredW-1:0] pending_sub,
  input  logic             pending_inc,
  output logic [CredW-1:0] remote,
  output logic [CredW-1:0] pending,
  output logic             ovf
);
  localparam int W = CredW + 1;
  logic [W-1:0] r_sum, p_sum;
  logic r_ovf, p_ovf;
  always_comb begin
    r_sum = W'(remote) - W'(remote_dec) + W'(remote_add);
    p_sum = W'(pending) - W'(pending_sub) + W'(pending_inc);
    r_ovf = r_sum > W'(NumCred);
    p_ovf = p_sum > W'(NumCred);
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      remote  <= CredW'(NumCred);
      pending <= '0;
      ovf     <= 1'b0;
    end else begin
      remote  <= r_ovf ? CredW'(NumCred) : r_sum[CredW-1:0];
      pending <= p_ovf ? CredW'(NumCred) : p_sum[CredW-1:0];
      ovf     <= ovf | r_ovf | p_ovf;
    end
  end
endmodule

// File: rtl/noc_bridge_vc_scheduler.sv
// noc_bridge_vc_scheduler: credit-aware round-robin VC scheduler driving one registered AXIS packet stage
module noc_bridge_vc_scheduler
  import noc_bridge_pkg::*;
#(
  parameter int NumVc = 2,
  parameter int NumCred = NumCredNocBridge,
  parameter int ForceSendThresh = NumCred - 4,
  localparam int IdxW = (NumVc > 1) ? $clog2(NumVc) : 1,
  localparam int CredW = $clog2(NumCred + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [NumVc-1:0] vc_valid_i,
  output logic             load_o,
  output logic [IdxW-1:0]  sel_vc_o,
  output logic [NumVc-1:0] vc_pop_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [IdxW-1:0]  out_data_vc_o,
  output logic             out_data_valid_o,
  output logic [IdxW-1:0]  out_cred_vc_o,
  output logic [CredW-1:0] out_cred_o,
  input  logic             cred_rcvd_valid_i,
  input  logic [IdxW-1:0]  cred_rcvd_vc_i,
  input  logic [CredW-1:0] cred_rcvd_i,
  input  logic [NumVc-1:0] rx_pop_i,
  output logic             err_o
);
  logic [NumVc-1:0][CredW-1:0] remote, pending;
  logic [NumVc-1:0] elig, ovf;
  logic [IdxW-1:0] rr, win, cv, j;
  logic [CredW-1:0] max_p;
  logic any_elig, can_load;
  always_comb begin
    win = '0;
    any_elig = 1'b0;
    j = '0;
    for (int i = NumVc - 1; i >= 0; i--) begin
      j = IdxW'((int'(rr) + i) % NumVc);
      if (elig[j]) begin
        win = j;
        any_elig = 1'b1;
      end
    end
    max_p = '0;
    cv = '0;
    for (int i = 0; i < NumVc; i++) begin
      if (pending[i] > max_p) begin
        max_p = pending[i];
        cv = IdxW'(i);
      end
    end
    can_load = !out_valid_o || out_ready_i;
    load_o = can_load && (any_elig || max_p >= CredW'(ForceSendThresh));
    sel_vc_o = load_o ? win : '0;
    vc_pop_o = (load_o && any_elig) ? NumVc'(1) << win : '0;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_o      <= 1'b0;
      out_data_vc_o    <= '0;
      out_data_valid_o <= 1'b0;
      out_cred_vc_o    <= '0;
      out_cred_o       <= '0;
      rr               <= '0;
    end else if (load_o) begin
      out_valid_o      <= 1'b1;
      out_data_vc_o    <= win;
      out_data_valid_o <= any_elig;
      out_cred_vc_o    <= cv;
      out_cred_o       <= max_p;
      if (any_elig) rr <= (win == IdxW'(NumVc - 1)) ? '0 : win + IdxW'(1);
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end
  for (genvar g = 0; g < NumVc; g++) begin : g_vc
    noc_bridge_vc_credit_counter #(.NumCred(NumCred), .CredW(CredW)) u_cnt (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .remote_dec (vc_pop_o[g]),
      .remote_add ((cred_rcvd_valid_i && cred_rcvd_vc_i == IdxW'(g)) ? cred_rcvd_i : '0),
      .pending_sub((load_o && cv == IdxW'(g)) ? max_p : '0),
      .pending_inc(rx_pop_i[g]),
      .remote     (remote[g]),
      .pending    (pending[g]),
      .ovf        (ovf[g])
    );
    assign elig[g] = vc_valid_i[g] && remote[g] != '0;
  end
  assign err_o = |ovf;
endmodule

// File: tb/tb_noc_bridge_vc_scheduler.sv
// tb_noc_bridge_vc_scheduler: directed stimulus with a queue scoreboard checking every accepted packet
module tb_noc_bridge_vc_scheduler;
  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  logic [1:0] vc_valid_i = '0;
  logic load_o;
  logic sel_vc_o;
  logic [1:0] vc_pop_o;
  logic out_valid_o;
  logic out_ready_i = 1'b1;
  logic out_data_vc_o;
  logic out_data_valid_o;
  logic out_cred_vc_o;
  logic [3:0] out_cred_o;
  logic cred_rcvd_valid_i = 1'b0;
  logic cred_rcvd_vc_i = 1'b0;
  logic [3:0] cred_rcvd_i = '0;
  logic [1:0] rx_pop_i = '0;
  logic err_o;
  typedef struct {int dvc; int dv; int cvc; int cred;} pkt_t;
  pkt_t exp_q[$];
  int n_cmp = 0;
  int n_err = 0;
  int n_load = 0;
  int base;
  noc_bridge_vc_scheduler dut (
    .clk_i(clk_i), .rst_i(rst_i), .vc_valid_i(vc_valid_i), .load_o(load_o), .sel_vc_o(sel_vc_o),
    .vc_pop_o(vc_pop_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_vc_o(out_data_vc_o), .out_data_valid_o(out_data_valid_o), .out_cred_vc_o(out_cred_vc_o),
    .out_cred_o(out_cred_o), .cred_rcvd_valid_i(cred_rcvd_valid_i), .cred_rcvd_vc_i(cred_rcvd_vc_i),
    .cred_rcvd_i(cred_rcvd_i), .rx_pop_i(rx_pop_i), .err_o(err_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask
  task automatic push(input int dvc, input int dv, input int cvc, input int cred);
    pkt_t p;
    p.dvc = dvc;
    p.dv = dv;
    p.cvc = cvc;
    p.cred = cred;
    exp_q.push_back(p);
  endtask
  task automatic credit(input logic vc, input logic [3:0] amt);
    cred_rcvd_valid_i = 1'b1;
    cred_rcvd_vc_i = vc;
    cred_rcvd_i = amt;
    tick();
    cred_rcvd_valid_i = 1'b0;
    cred_rcvd_i = '0;
  endtask
  always @(negedge clk_i) begin
    if (!rst_i) begin
      if (load_o) n_load++;
      if (out_valid_o && out_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pkt: got vc %0d valid %0d cvc %0d cred %0d required none", out_data_vc_o, out_data_valid_o, out_cred_vc_o, out_cred_o);
        end else begin
          pkt_t e;
          e = exp_q.pop_front();
          chk("pkt_data_vc", 32'(out_data_vc_o), e.dvc);
          chk("pkt_data_valid", 32'(out_data_valid_o), e.dv);
          chk("pkt_cred_vc", 32'(out_cred_vc_o), e.cvc);
          chk("pkt_cred", 32'(out_cred_o), e.cred);
        end
      end
    end
  end
  initial begin
    #3;
    chk("rst_out_valid", 32'(out_valid_o), 0);
    chk("rst_err", 32'(err_o), 0);
    chk("rst_load", 32'(load_o), 0);
    chk("rst_cred", 32'(out_cred_o), 0);
    chk("rst_data_vc", 32'(out_data_vc_o), 0);
    tick();
    rst_i = 1'b0;
    tick();
    base = n_load;
    for (int i = 0; i < 16; i++) push(i % 2, 1, 0, 0);
    vc_valid_i = 2'b11;
    repeat (20) tick();
    chk("sat_loads", n_load - base, 16);
    chk("sat_stop", 32'(load_o), 0);
    credit(1'b0, 4'd3);
    base = n_load;
    for (int i = 0; i < 3; i++) push(0, 1, 0, 0);
    repeat (8) tick();
    chk("refill_loads", n_load - base, 3);
    chk("refill_stop", 32'(load_o), 0);
    vc_valid_i = 2'b00;
    rx_pop_i = 2'b10;
    repeat (3) tick();
    chk("force_below", 32'(load_o), 0);
    tick();
    rx_pop_i = 2'b00;
    #1;
    chk("force_load", 32'(load_o), 1);
    chk("force_pop", 32'(vc_pop_o), 0);
    push(0, 0, 1, 4);
    tick();
    chk("force_drained", 32'(load_o), 0);
    credit(1'b0, 4'd5);
    rx_pop_i = 2'b01;
    repeat (3) tick();
    vc_valid_i = 2'b01;
    cred_rcvd_valid_i = 1'b1;
    cred_rcvd_vc_i = 1'b0;
    cred_rcvd_i = 4'd2;
    #1;
    chk("sim_load", 32'(load_o), 1);
    chk("sim_sel", 32'(sel_vc_o), 0);
    chk("sim_pop", 32'(vc_pop_o), 1);
    push(0, 1, 0, 3);
    tick();
    vc_valid_i = 2'b00;
    cred_rcvd_valid_i = 1'b0;
    cred_rcvd_i = '0;
    repeat (3) tick();
    rx_pop_i = 2'b00;
    #1;
    chk("sim_pending_left", 32'(load_o), 1);
    push(0, 0, 0, 4);
    tick();
    base = n_load;
    for (int i = 0; i < 6; i++) push(0, 1, 0, 0);
    vc_valid_i = 2'b01;
    repeat (10) tick();
    chk("sim_remote_6", n_load - base, 6);
    vc_valid_i = 2'b00;
    out_ready_i = 1'b0;
    credit(1'b0, 4'd2);
    vc_valid_i = 2'b01;
    #1;
    chk("bp_first_load", 32'(load_o), 1);
    push(0, 1, 0, 0);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(out_valid_o), 1);
      chk("bp_no_load", 32'(load_o), 0);
      chk("bp_data_valid", 32'(out_data_valid_o), 1);
      chk("bp_data_vc", 32'(out_data_vc_o), 0);
      tick();
    end
    out_ready_i = 1'b1;
    #1;
    chk("bp_release_load", 32'(load_o), 1);
    push(0, 1, 0, 0);
    tick();
    vc_valid_i = 2'b00;
    repeat (3) tick();
    credit(1'b0, 4'd8);
    chk("ovf_none", 32'(err_o), 0);
    credit(1'b0, 4'd1);
    chk("ovf_set", 32'(err_o), 1);
    repeat (3) tick();
    chk("ovf_sticky", 32'(err_o), 1);
    base = n_load;
    for (int i = 0; i < 8; i++) push(0, 1, 0, 0);
    vc_valid_i = 2'b01;
    repeat (12) tick();
    chk("ovf_remote_8", n_load - base, 8);
    vc_valid_i = 2'b00;
    credit(1'b0, 4'd1);
    out_ready_i = 1'b0;
    vc_valid_i = 2'b01;
    tick();
    vc_valid_i = 2'b00;
    chk("pre_rst_valid", 32'(out_valid_o), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid_o), 0);
    chk("arst_err", 32'(err_o), 0);
    chk("arst_data_valid", 32'(out_data_valid_o), 0);
    tick();
    rst_i = 1'b0;
    out_ready_i = 1'b1;
    vc_valid_i = 2'b01;
    #1;
    chk("post_rst_load", 32'(load_o), 1);
    push(0, 1, 0, 0);
    tick();
    vc_valid_i = 2'b00;
    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
